i2c_slave_if: RTL and testbench
===============================

I2C_SLAVE_IF -- requirements
Module: i2c_slave_if

Interface
REQ-001 Parameter device_address, default 8'h42, slave address in 8-bit write form; bits [7:1] are the 7-bit address and bit 0 is ignored.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  system clock; SHALL run at least 16x the SCL frequency.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  1 = respond to the address; 0 = never ACK and never strobe.
REQ-006 scl_io  input  1  I2C clock (slave does not stretch).
REQ-007 sda_io  inout  1  I2C data, open-drain: driven 0 or released to Z, never driven 1.
REQ-008 addr_strobe  output  1  one-clk pulse when the first data byte of a write (register address) is received.
REQ-009 write_strobe  output  1  one-clk pulse for each subsequent write data byte.
REQ-010 read_strobe  output  1  one-clk pulse each time rdata is sampled for transmission.
REQ-011 wdata  output  8  last received data byte; stable from 1 clk before a strobe until the next byte completes.
REQ-012 rdata  input  8  byte to transmit on reads; sampled at read_strobe.

Function
REQ-013 SCL and SDA SHALL pass through 2-FF synchronisers; all edge detection uses the synchronised values.
REQ-014 START = SDA falls while SCL high; STOP = SDA rises while SCL high; both recognised in every state, except that SDA changes caused by the slave's own drive are not START/STOP events.
REQ-015 States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
REQ-016 START (including repeated START) -> ADDR, bit counter cleared, first_byte flag set; STOP -> IDLE with SDA released.
REQ-017 Bits SHALL be sampled on SCL rising edges, MSB first.
REQ-018 ADDR: after 8 bits, if enable=1 and byte[7:1]==device_address[7:1] -> ADDR_ACK; otherwise -> IGNORE (no ACK, no strobes until START/STOP).
REQ-019 ACK: drive SDA low after the SCL falling edge that ends bit 8; release after the SCL falling edge that ends bit 9.
REQ-020 ADDR_ACK with R/W=0 -> WR_BYTE.
REQ-021 WR_BYTE: after 8 bits, update wdata, then pulse addr_strobe if first_byte else write_strobe; clear first_byte; -> WR_ACK (slave ACKs) -> WR_BYTE.
REQ-022 ADDR_ACK with R/W=1 -> RD_BYTE: at the ACK-ending SCL fall, pulse read_strobe, latch rdata into the shift register, and drive the MSB.
REQ-023 RD_BYTE: shift the next bit onto SDA after each SCL fall (0 -> drive low, 1 -> release); after 8 bits release SDA -> RD_ACK.
REQ-024 RD_ACK: sample the master bit on SCL rise; ACK(0) -> reload as in REQ-022; NACK(1) -> IGNORE until STOP/START.
REQ-025 A repeated START mid-byte SHALL abort the byte without any strobe.

Reset
REQ-026 While rst_n=0: state IDLE, SDA released (Z), all strobes 0, wdata 8'h00, shift register/counters 0, first_byte 0, synchronisers loaded with 1 (idle bus).
REQ-027 Reset deasserted mid-transfer: the slave SHALL stay in IDLE until the next START.

Structure
REQ-028 The shared package SHALL hold the state enumeration, the DEFAULT_ADDR=8'h42 constant and the bit-count width.
REQ-029 One sub-module, i2c_bus_sync, SHALL synchronise SCL/SDA and output scl_rise, scl_fall, start_det and stop_det pulses.
REQ-030 The SDA pad SHALL be a tri-state buffer with input 0 and tristate = ~drive_low; the module also reads the bus back through this buffer.

Verification
REQ-031 Write 0x42, 0x01, 0xA5, STOP -> three ACKs; addr_strobe with wdata=0x01; write_strobe with wdata=0xA5.
REQ-032 Read 0x43 with rdata=0x5C, master NACK, STOP -> ACK, SDA bits 0,1,0,1,1,1,0,0; one read_strobe; SDA then released.
REQ-033 Address 0x44, or enable=0 with 0x42 -> SDA stays Z on the 9th clock; no strobes.
REQ-034 Write 0x42, 0x03, repeated START, read 0x43 with rdata=0xFF, master ACK then NACK -> addr_strobe with wdata=0x03; two read_strobes; 16 released data bits.
REQ-035 rst_n low during the ACK of a write -> SDA released immediately; state IDLE; no further strobes until a new START.

Source files
------------

// File: rtl/i2c_slave_if_pkg.sv
// Shared definitions for the I2C register-style slave: FSM states, default
// address and bit counter width.
package i2c_slave_if_pkg;

    localparam logic [7:0] DEFAULT_ADDR = 8'h42;
    localparam int         BIT_CNT_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/i2c_slave_if_if.sv
// Host-side handshake of the I2C slave: enable, byte strobes and data.
interface i2c_slave_if_if;

    logic       enable;
    logic       addr_strobe;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport slave (
        input  enable, rdata,
        output addr_strobe, write_strobe, read_strobe, wdata
    );

    modport master (
        output enable, rdata,
        input  addr_strobe, write_strobe, read_strobe, wdata
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronisers for SCL/SDA plus SCL edge and START/STOP detection,
// all derived from the synchronised copies.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_ff;
    logic [1:0] sda_ff;
    logic       scl_q;
    logic       sda_q;
    logic       scl_s;

    // Reset to an idle bus (both lines high) so no edge is seen on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_ff <= 2'b11;
            sda_ff <= 2'b11;
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[0], scl_in};
            sda_ff <= {sda_ff[0], sda_in};
            scl_q  <= scl_ff[1];
            sda_q  <= sda_ff[1];
        end
    end

    assign scl_s     = scl_ff[1];
    assign sda_s     = sda_ff[1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_slave_if.sv
// I2C slave exposing a register-address / data-byte strobe interface.
// Open-drain SDA, no clock stretching; clk must be >= 16x SCL.
module i2c_slave_if
    import i2c_slave_if_pkg::*;
#(
    parameter logic [7:0] device_address = DEFAULT_ADDR
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           scl_io,
    inout  wire            sda_io,
    i2c_slave_if_if.slave  host
);

    state_t               state, state_n;
    logic [BIT_CNT_W-1:0] bit_cnt, cnt_n;
    logic [7:0]           shreg, sh_n;
    logic [7:0]           wdata_r, wdata_n;
    logic                 first_byte, first_n;
    logic                 rw, rw_n;
    logic                 drive_low, drv_n;
    logic                 addr_stb, addr_stb_n;
    logic                 wr_stb, wr_stb_n;
    logic                 rd_stb, rd_stb_n;
    logic [3:0]           drv_hist;

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic own_edge, bus_start, bus_stop;

    assign sda_io = drive_low ? 1'b0 : 1'bz;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_io),
        .sda_in    (sda_io),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    // SDA transitions we caused ourselves reach the detector a few clocks late;
    // mask events while our own drive is still settling through the synchroniser.
    assign own_edge  = (drv_hist != {4{drive_low}});
    assign bus_start = start_det & ~own_edge;
    assign bus_stop  = stop_det & ~own_edge;

    always_comb begin
        state_n    = state;
        cnt_n      = bit_cnt;
        sh_n       = shreg;
        wdata_n    = wdata_r;
        first_n    = first_byte;
        rw_n       = rw;
        drv_n      = drive_low;
        addr_stb_n = 1'b0;
        wr_stb_n   = 1'b0;
        rd_stb_n   = 1'b0;

        if (bus_start) begin
            state_n = ST_ADDR;
            cnt_n   = '0;
            sh_n    = '0;
            first_n = 1'b1;
            drv_n   = 1'b0;
        end else if (bus_stop) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            drv_n   = 1'b0;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (bit_cnt == BIT_CNT_W'(8)) begin
                        cnt_n = '0;
                        if (host.enable && (shreg[7:1] == device_address[7:1])) begin
                            state_n = ST_ADDR_ACK;
                            rw_n    = shreg[0];
                        end else begin
                            state_n = ST_IGNORE;
                        end
                    end else if (scl_rise) begin
                        sh_n  = {shreg[6:0], sda_s};
                        cnt_n = bit_cnt + 1'b1;
                    end
                end

                ST_WR_BYTE: begin
                    if (bit_cnt == BIT_CNT_W'(8)) begin
                        addr_stb_n = first_byte;
                        wr_stb_n   = ~first_byte;
                        first_n    = 1'b0;
                        cnt_n      = '0;
                        state_n    = ST_WR_ACK;
                    end else if (scl_rise) begin
                        sh_n  = {shreg[6:0], sda_s};
                        cnt_n = bit_cnt + 1'b1;
                        // Publish the byte one clock ahead of its strobe.
                        if (bit_cnt == BIT_CNT_W'(7))
                            wdata_n = {shreg[6:0], sda_s};
                    end
                end

                // First fall ends bit 8 and starts our ACK; second fall ends it.
                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!drive_low) begin
                            drv_n = 1'b1;
                        end else if (state == ST_ADDR_ACK && rw) begin
                            rd_stb_n = 1'b1;
                            sh_n     = host.rdata;
                            drv_n    = ~host.rdata[7];
                            cnt_n    = '0;
                            state_n  = ST_RD_BYTE;
                        end else begin
                            drv_n   = 1'b0;
                            cnt_n   = '0;
                            state_n = ST_WR_BYTE;
                        end
                    end
                end

                // bit_cnt counts SCL falls after the MSB was put on the bus.
                ST_RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt == BIT_CNT_W'(7)) begin
                            drv_n   = 1'b0;
                            cnt_n   = '0;
                            state_n = ST_RD_ACK;
                        end else begin
                            drv_n = ~shreg[6];
                            sh_n  = {shreg[6:0], 1'b0};
                            cnt_n = bit_cnt + 1'b1;
                        end
                    end
                end

                // bit_cnt == 1 records that the master acknowledged.
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s)
                            state_n = ST_IGNORE;
                        else
                            cnt_n = BIT_CNT_W'(1);
                    end else if (scl_fall && bit_cnt == BIT_CNT_W'(1)) begin
                        rd_stb_n = 1'b1;
                        sh_n     = host.rdata;
                        drv_n    = ~host.rdata[7];
                        cnt_n    = '0;
                        state_n  = ST_RD_BYTE;
                    end
                end

                ST_IDLE, ST_IGNORE: begin
                    drv_n = 1'b0;
                end

                default: begin
                    state_n = ST_IDLE;
                    drv_n   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            wdata_r    <= '0;
            first_byte <= 1'b0;
            rw         <= 1'b0;
            drive_low  <= 1'b0;
            addr_stb   <= 1'b0;
            wr_stb     <= 1'b0;
            rd_stb     <= 1'b0;
            drv_hist   <= '0;
        end else begin
            state      <= state_n;
            bit_cnt    <= cnt_n;
            shreg      <= sh_n;
            wdata_r    <= wdata_n;
            first_byte <= first_n;
            rw         <= rw_n;
            drive_low  <= drv_n;
            addr_stb   <= addr_stb_n;
            wr_stb     <= wr_stb_n;
            rd_stb     <= rd_stb_n;
            drv_hist   <= {drv_hist[2:0], drive_low};
        end
    end

    assign host.addr_strobe  = addr_stb;
    assign host.write_strobe = wr_stb;
    assign host.read_strobe  = rd_stb;
    assign host.wdata        = wdata_r;

endmodule

// File: tb/tb_i2c_slave_if.sv
// Bench for i2c_slave_if: bit-banged I2C master, strobe logger and a
// transaction-level expectation model (address match -> ACKs and strobes).
module tb_i2c_slave_if;
    import i2c_slave_if_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic scl   = 1'b1;
    logic m_low = 1'b0;
    wire  sda;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_slave_if_if host ();

    i2c_slave_if #(.device_address(DEFAULT_ADDR)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .scl_io (scl),
        .sda_io (sda),
        .host   (host)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Strobe log entry: {wdata stable vs previous clk, kind (1 addr, 2 write, 3 read), data}
    logic [10:0] ev_q [$];
    logic [10:0] exp_q [$];
    logic [7:0]  wdata_d;
    logic [7:0]  buf_b [4];

    always @(negedge clk) begin
        if (host.addr_strobe)  ev_q.push_back({host.wdata === wdata_d, 2'd1, host.wdata});
        if (host.write_strobe) ev_q.push_back({host.wdata === wdata_d, 2'd2, host.wdata});
        if (host.read_strobe)  ev_q.push_back({1'b1, 2'd3, host.rdata});
        wdata_d <= host.wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_match(input logic [7:0] a, input logic en);
        logic [7:0] d;
        d = DEFAULT_ADDR;
        return en && (a[7:1] == d[7:1]);
    endfunction

    task automatic q();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b;
        q(); scl = 1'b1; q(); q(); scl = 1'b0; q();
    endtask

    task automatic recv_bit(output logic b);
        m_low = 1'b0;
        q(); scl = 1'b1; q(); b = sda; q(); scl = 1'b0; q();
    endtask

    task automatic i2c_start();
        m_low = 1'b0;
        q(); scl = 1'b1; q(); m_low = 1'b1; q(); scl = 1'b0; q();
    endtask

    task automatic i2c_stop();
        m_low = 1'b1;
        q(); scl = 1'b1; q(); m_low = 1'b0; q(); q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic bt;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(bt);
        ack = ~bt;
    endtask

    task automatic read_bits(output logic [7:0] v);
        logic bt;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(bt);
            v[i] = bt;
        end
    endtask

    task automatic wr_bytes(input string tag, input logic [7:0] a, input int n);
        logic ack, m;
        m = addr_match(a, host.enable);
        write_byte(a, ack);
        chk({tag, ":addr_ack"}, 32'(ack), 32'(m));
        for (int i = 0; i < n; i++) begin
            write_byte(buf_b[i], ack);
            chk({tag, ":data_ack"}, 32'(ack), 32'(m));
            if (m) exp_q.push_back({1'b1, (i == 0) ? 2'd1 : 2'd2, buf_b[i]});
        end
    endtask

    task automatic rd_bytes(input string tag, input logic [7:0] a, input int n);
        logic       ack, m;
        logic [7:0] v;
        m = addr_match(a, host.enable);
        host.rdata = buf_b[0];
        write_byte(a, ack);
        chk({tag, ":addr_ack"}, 32'(ack), 32'(m));
        for (int i = 0; i < n; i++) begin
            read_bits(v);
            chk({tag, ":rd_byte"}, 32'(v), 32'(m ? buf_b[i] : 8'hFF));
            if (m) exp_q.push_back({1'b1, 2'd3, buf_b[i]});
            if (i < n - 1) host.rdata = buf_b[i + 1];
            send_bit(i == n - 1);
        end
        chk({tag, ":released"}, 32'(sda), 32'(1'b1));
    endtask

    task automatic check_events(input string tag, input int base);
        chk({tag, ":n_strobes"}, 32'(ev_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < ev_q.size())
                chk({tag, ":strobe"}, 32'(ev_q[base + i]), 32'(exp_q[i]));
        exp_q.delete();
    endtask

    initial begin
        int         base;
        logic       ack;
        logic [7:0] a;
        int         n;

        host.enable = 1'b1;
        host.rdata  = 8'h00;

        // Reset state
        repeat (4) @(negedge clk);
        chk("rst:sda", 32'(sda), 32'(1'b1));
        chk("rst:addr_strobe", 32'(host.addr_strobe), 32'(1'b0));
        chk("rst:write_strobe", 32'(host.write_strobe), 32'(1'b0));
        chk("rst:read_strobe", 32'(host.read_strobe), 32'(1'b0));
        chk("rst:wdata", 32'(host.wdata), 32'(8'h00));
        rst_n = 1'b1;
        q();

        // Register write: address byte then data byte
        base = ev_q.size();
        buf_b[0] = 8'h01; buf_b[1] = 8'hA5;
        i2c_start(); wr_bytes("wr", 8'h42, 2); i2c_stop();
        check_events("wr", base);
        chk("wr:wdata", 32'(host.wdata), 32'(8'hA5));

        // Single-byte read ending with NACK
        base = ev_q.size();
        buf_b[0] = 8'h5C;
        i2c_start(); rd_bytes("rd", 8'h43, 1); i2c_stop();
        check_events("rd", base);

        // Wrong address, then right address with enable low
        base = ev_q.size();
        buf_b[0] = 8'h55;
        i2c_start(); wr_bytes("badaddr", 8'h44, 1); i2c_stop();
        host.enable = 1'b0;
        i2c_start(); wr_bytes("disabled", 8'h42, 1); i2c_stop();
        host.enable = 1'b1;
        check_events("noack", base);

        // Write register address, repeated START, two-byte read
        base = ev_q.size();
        buf_b[0] = 8'h03;
        i2c_start(); wr_bytes("rs_wr", 8'h42, 1);
        buf_b[0] = 8'hFF; buf_b[1] = 8'hFF;
        i2c_start(); rd_bytes("rs_rd", 8'h43, 2); i2c_stop();
        check_events("rstart", base);

        // Repeated START in the middle of a byte aborts it silently
        base = ev_q.size();
        i2c_start(); write_byte(8'h42, ack);
        chk("abort:addr_ack", 32'(ack), 32'(1'b1));
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        buf_b[0] = 8'h09;
        i2c_start(); wr_bytes("abort", 8'h42, 1); i2c_stop();
        check_events("abort", base);

        // Reset asserted while the slave is driving a write ACK
        base = ev_q.size();
        i2c_start(); write_byte(8'h42, ack);
        chk("rstack:addr_ack", 32'(ack), 32'(1'b1));
        for (int i = 7; i >= 0; i--) send_bit(i == 0);
        exp_q.push_back({1'b1, 2'd1, 8'h01});
        m_low = 1'b0; q(); scl = 1'b1; q();
        chk("rstack:driving", 32'(sda), 32'(1'b0));
        rst_n = 1'b0;
        #1;
        chk("rstack:released", 32'(sda), 32'(1'b1));
        q(); scl = 1'b0; q();
        rst_n = 1'b1;
        q();
        write_byte(8'h77, ack);
        chk("rstack:idle_no_ack", 32'(ack), 32'(1'b0));
        i2c_stop();
        check_events("rstack", base);
        base = ev_q.size();
        buf_b[0] = 8'h10;
        i2c_start(); wr_bytes("recover", 8'h42, 1); i2c_stop();
        check_events("recover", base);

        // Randomised transactions against the address-match model
        for (int t = 0; t < 10; t++) begin
            case ($urandom_range(0, 2))
                0:       a = 8'h42;
                1:       a = 8'h43;
                default: a = 8'($urandom_range(0, 255));
            endcase
            host.enable = ($urandom_range(0, 3) != 0);
            n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) buf_b[i] = 8'($urandom_range(0, 255));
            base = ev_q.size();
            i2c_start();
            if (a[0]) rd_bytes("rand_rd", a, n);
            else      wr_bytes("rand_wr", a, n);
            i2c_stop();
            check_events("rand", base);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
